// File: rtl/cm_topk_pkg.sv
// cm_topk_pkg
// Shared types and constants for the top-k sorted CAM that follows the
// count-min sketch stage.
//   ADDR_SIZE / CNT_SIZE : widths of a stored address and its estimate
//   entry_t              : one CAM slot {valid, addr, cnt}
//   state_t              : dump FSM states
package cm_topk_pkg;

    localparam int ADDR_SIZE = 22;
    localparam int CNT_SIZE  = 32;
    localparam int NUM_HASH  = 4;
    localparam int NUM_ENTRY = 16;

    typedef struct packed {
        logic                 valid;
        logic [ADDR_SIZE-1:0] addr;
        logic [CNT_SIZE-1:0]  cnt;
    } entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

endpackage

// File: rtl/cm_topk_sorted_cam_min_reduce.sv
// cm_min_reduce
// Combinational NUM_HASH-way unsigned minimum, built as a balanced binary
// tree laid out heap-style: node 0 is the root, leaves occupy the last
// NUM_HASH slots. NUM_HASH must be a power of two.
// Ports:
//   in_cnt_array : NUM_HASH packed counts, row k at [k*CNT_SIZE +: CNT_SIZE]
//   min_cnt      : smallest of the NUM_HASH counts
module cm_min_reduce #(
    parameter int NUM_HASH = cm_topk_pkg::NUM_HASH,
    parameter int CNT_SIZE = cm_topk_pkg::CNT_SIZE
) (
    input  logic [NUM_HASH*CNT_SIZE-1:0] in_cnt_array,
    output logic [CNT_SIZE-1:0]          min_cnt
);

    logic [CNT_SIZE-1:0] node_s [2*NUM_HASH-1];

    // Load the leaves, then reduce pairwise from the bottom of the tree up.
    always_comb begin
        for (int i = 0; i < NUM_HASH; i++) begin
            node_s[NUM_HASH-1+i] = in_cnt_array[i*CNT_SIZE +: CNT_SIZE];
        end
        for (int i = NUM_HASH-2; i >= 0; i--) begin
            node_s[i] = (node_s[2*i+1] < node_s[2*i+2]) ? node_s[2*i+1] : node_s[2*i+2];
        end
        min_cnt = node_s[0];
    end

endmodule

// File: rtl/cm_topk_sorted_cam.sv
// cm_topk_sorted_cam
// Reduces each sketch sample to its count-min estimate and maintains a CAM
// of the NUM_ENTRY hottest addresses, sorted by descending estimate. A
// handshaked dump port streams the whole table, one entry per beat.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   query_rst_n     : synchronous active-low clear of all state
//   in_valid/in_addr/in_cnt_array : sample from the sketch
//   thresh          : minimum estimate for inserting a new address
//   dump_req        : pulse that starts a dump (ignored while dumping)
//   out_valid/out_ready/out_addr/out_cnt/out_last : dump stream
//   busy            : dump in progress
//   drop_cnt        : saturating count of samples discarded during dumps
// The stored entry_t is sized by the package; ADDR_SIZE/CNT_SIZE overrides
// must match the package constants.
module cm_topk_sorted_cam #(
    parameter int NUM_HASH  = cm_topk_pkg::NUM_HASH,
    parameter int ADDR_SIZE = cm_topk_pkg::ADDR_SIZE,
    parameter int CNT_SIZE  = cm_topk_pkg::CNT_SIZE,
    parameter int NUM_ENTRY = cm_topk_pkg::NUM_ENTRY,
    parameter int IDX_SIZE  = $clog2(NUM_ENTRY)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         query_rst_n,
    input  logic                         in_valid,
    input  logic [ADDR_SIZE-1:0]         in_addr,
    input  logic [NUM_HASH*CNT_SIZE-1:0] in_cnt_array,
    input  logic [CNT_SIZE-1:0]          thresh,
    input  logic                         dump_req,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_SIZE-1:0]         out_addr,
    output logic [CNT_SIZE-1:0]          out_cnt,
    output logic                         out_last,
    output logic                         busy,
    output logic [15:0]                  drop_cnt
);

    import cm_topk_pkg::*;

    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(NUM_ENTRY-1);

    // Stage M
    logic [CNT_SIZE-1:0]  min_cnt_s;
    logic                 m_valid_r;
    logic [ADDR_SIZE-1:0] m_addr_r;
    logic [CNT_SIZE-1:0]  m_cnt_r;

    // CAM contents and update path
    entry_t               ent_r     [NUM_ENTRY];
    entry_t               ent_upd_s [NUM_ENTRY];
    entry_t               ent_nxt_s [NUM_ENTRY];
    entry_t               new_ent_s;
    logic [NUM_ENTRY-1:0] hit_vec_s;
    logic [NUM_ENTRY-1:0] lt_vec_s;
    logic [NUM_ENTRY-1:0] cand_vec_s;
    logic                 hit_any_s;
    logic [IDX_SIZE-1:0]  hit_idx_s;
    logic                 pos_found_s;
    logic [IDX_SIZE-1:0]  pos_s;
    logic [IDX_SIZE-1:0]  top_idx_s;
    logic                 do_upd_s;

    // Dump FSM and outputs
    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDX_SIZE-1:0]  idx_r;
    logic [IDX_SIZE-1:0]  idx_nxt_s;
    logic                 out_valid_r;
    logic [ADDR_SIZE-1:0] out_addr_r;
    logic [CNT_SIZE-1:0]  out_cnt_r;
    logic                 out_last_r;
    logic                 busy_r;
    logic [15:0]          drop_cnt_r;

    cm_min_reduce #(
        .NUM_HASH (NUM_HASH),
        .CNT_SIZE (CNT_SIZE)
    ) u_min (
        .in_cnt_array (in_cnt_array),
        .min_cnt      (min_cnt_s)
    );

    // Stage M register: capture the address and its count-min estimate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_addr_r  <= '0;
            m_cnt_r   <= '0;
        end else if (!query_rst_n) begin
            m_valid_r <= 1'b0;
            m_addr_r  <= '0;
            m_cnt_r   <= '0;
        end else begin
            m_valid_r <= in_valid;
            if (in_valid) begin
                m_addr_r <= in_addr;
                m_cnt_r  <= min_cnt_s;
            end
        end
    end

    // Match and priority-encode the hit slot h and the insertion slot p.
    // Descending loops with a ternary leave the lowest matching index.
    always_comb begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
            hit_vec_s[i] = ent_r[i].valid && (ent_r[i].addr == m_addr_r);
            lt_vec_s[i]  = ent_r[i].cnt < m_cnt_r;
        end
        hit_any_s = |hit_vec_s;
        hit_idx_s = '0;
        for (int i = NUM_ENTRY-1; i >= 0; i--) begin
            hit_idx_s = hit_vec_s[i] ? IDX_SIZE'(i) : hit_idx_s;
        end
        // On a hit, p is the first smaller entry above h, or h itself.
        // On a miss, p is the first free or smaller slot.
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (hit_any_s) begin
                cand_vec_s[i] = hit_vec_s[i] || (lt_vec_s[i] && (IDX_SIZE'(i) < hit_idx_s));
            end else begin
                cand_vec_s[i] = !ent_r[i].valid || lt_vec_s[i];
            end
        end
        pos_found_s = |cand_vec_s;
        pos_s       = '0;
        for (int i = NUM_ENTRY-1; i >= 0; i--) begin
            pos_s = cand_vec_s[i] ? IDX_SIZE'(i) : pos_s;
        end
        top_idx_s = hit_any_s ? hit_idx_s : LAST_IDX;
        new_ent_s = '{valid: 1'b1, addr: m_addr_r, cnt: m_cnt_r};
        // Below-threshold misses and samples with no slot leave the CAM alone;
        // updates are frozen while a dump is streaming.
        do_upd_s  = m_valid_r && (state_r == IDLE) && pos_found_s &&
                    (hit_any_s || (m_cnt_r >= thresh));
    end

    // Shift p..top down one slot and write the sample at p. On a miss top
    // is the last slot, so its old content falls off the end.
    always_comb begin
        ent_upd_s[0] = (pos_s == '0) ? new_ent_s : ent_r[0];
        for (int i = 1; i < NUM_ENTRY; i++) begin
            if (IDX_SIZE'(i) == pos_s) begin
                ent_upd_s[i] = new_ent_s;
            end else if ((IDX_SIZE'(i) > pos_s) && (IDX_SIZE'(i) <= top_idx_s)) begin
                ent_upd_s[i] = ent_r[i-1];
            end else begin
                ent_upd_s[i] = ent_r[i];
            end
        end
        for (int i = 0; i < NUM_ENTRY; i++) begin
            ent_nxt_s[i] = do_upd_s ? ent_upd_s[i] : ent_r[i];
        end
    end

    // CAM storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                ent_r[i] <= '0;
            end
        end else if (!query_rst_n) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                ent_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                ent_r[i] <= ent_nxt_s[i];
            end
        end
    end

    // Dump FSM next-state: walk idx on each accepted beat.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (dump_req) begin
                    state_nxt_s = DUMP;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = idx_r;
                end
            end
            DUMP: begin
                // out_valid is always high here, so out_ready alone accepts.
                if (out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = IDLE;
                        idx_nxt_s   = '0;
                    end else begin
                        state_nxt_s = DUMP;
                        idx_nxt_s   = idx_r + IDX_SIZE'(1);
                    end
                end else begin
                    state_nxt_s = DUMP;
                    idx_nxt_s   = idx_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
        end else if (!query_rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Registered dump outputs, loaded from the next-cycle entry so the first
    // beat already reflects an update landing on the dump_req edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_addr_r  <= '0;
            out_cnt_r   <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else if (!query_rst_n) begin
            out_valid_r <= 1'b0;
            out_addr_r  <= '0;
            out_cnt_r   <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_nxt_s == DUMP);
            busy_r      <= (state_nxt_s == DUMP);
            out_last_r  <= (state_nxt_s == DUMP) && (idx_nxt_s == LAST_IDX);
            if ((state_nxt_s == DUMP) && ent_nxt_s[idx_nxt_s].valid) begin
                out_addr_r <= ent_nxt_s[idx_nxt_s].addr;
                out_cnt_r  <= ent_nxt_s[idx_nxt_s].cnt;
            end else begin
                out_addr_r <= '0;
                out_cnt_r  <= '0;
            end
        end
    end

    // Count samples lost to a dump, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 16'h0000;
        end else if (!query_rst_n) begin
            drop_cnt_r <= 16'h0000;
        end else if (m_valid_r && (state_r == DUMP) && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_cnt   = out_cnt_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_cm_topk_sorted_cam.sv
// Self-checking bench for cm_topk_sorted_cam: a table of samples, each
// followed by a full dump compared against the expected sorted table via a
// scoreboard queue, plus hand-written sequences for back-to-back hits, a
// full CAM with eviction, stalls/drops during a dump and a mid-dump clear.
module tb_cm_topk_sorted_cam;

    localparam int NH = 4;
    localparam int AW = 22;
    localparam int CW = 32;
    localparam int NE = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           query_rst_n;
    logic           in_valid;
    logic [AW-1:0]  in_addr;
    logic [NH*CW-1:0] in_cnt_array;
    logic [CW-1:0]  thresh;
    logic           dump_req;
    logic           out_valid;
    logic           out_ready;
    logic [AW-1:0]  out_addr;
    logic [CW-1:0]  out_cnt;
    logic           out_last;
    logic           busy;
    logic [15:0]    drop_cnt;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] cnt;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] c0, c1, c2, c3;
        logic [CW-1:0] th;
        beat_t [4:0]   e;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vtab[$];

    always #5 clk = ~clk;

    cm_topk_sorted_cam dut (
        .clk          (clk),
        .rst          (rst),
        .query_rst_n  (query_rst_n),
        .in_valid     (in_valid),
        .in_addr      (in_addr),
        .in_cnt_array (in_cnt_array),
        .thresh       (thresh),
        .dump_req     (dump_req),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_cnt      (out_cnt),
        .out_last     (out_last),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [AW-1:0] a, input logic [CW-1:0] c);
        beat_t b;
        b.addr = a;
        b.cnt  = c;
        return b;
    endfunction

    function automatic logic [NH*CW-1:0] pack4(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                                               input logic [CW-1:0] c2, input logic [CW-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic add_vec(input logic [AW-1:0] a, input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                           input logic [CW-1:0] c2, input logic [CW-1:0] c3, input logic [CW-1:0] th,
                           input beat_t e0, input beat_t e1, input beat_t e2, input beat_t e3,
                           input beat_t e4);
        vec_t v;
        v.addr = a; v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3; v.th = th;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3; v.e[4] = e4;
        vtab.push_back(v);
    endtask

    task automatic sample(input logic [AW-1:0] a, input logic [NH*CW-1:0] cnts, input logic [CW-1:0] th);
        @(negedge clk);
        in_valid     = 1'b1;
        in_addr      = a;
        in_cnt_array = cnts;
        thresh       = th;
        @(negedge clk);
        in_valid     = 1'b0;
    endtask

    task automatic qrst();
        @(negedge clk);
        query_rst_n = 1'b0;
        @(negedge clk);
        query_rst_n = 1'b1;
    endtask

    // Expected contents after the 16-entry fill plus the 90 insertion.
    task automatic push_fill_expect();
        for (int i = 0; i < NE; i++) begin
            if (i <= 10)      exp_q.push_back(mk(AW'(32'h100 + i), CW'(100 - i)));
            else if (i == 11) exp_q.push_back(mk(AW'(32'h201), CW'(90)));
            else              exp_q.push_back(mk(AW'(32'h100 + i - 1), CW'(100 - (i - 1))));
        end
    endtask

    // Run one full dump, popping an expected beat on every accepted beat.
    task automatic run_dump(input bit toggle_ready, input int n_mid);
        int            cyc;
        int            beats;
        bit            held;
        logic [AW-1:0] hold_a;
        logic [CW-1:0] hold_c;
        bit            rdy;
        beat_t         e;
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        cyc = 0; beats = 0; held = 1'b0;
        while (beats < NE && cyc < 200) begin
            chk("dump_valid", 64'(out_valid), 64'd1);
            chk("dump_busy", 64'(busy), 64'd1);
            if (held) begin
                chk("hold_addr", 64'(out_addr), 64'(hold_a));
                chk("hold_cnt", 64'(out_cnt), 64'(hold_c));
            end
            rdy = toggle_ready ? ((cyc % 3) != 1) : 1'b1;
            out_ready = rdy;
            in_valid = (cyc >= 1) && (cyc <= n_mid);
            in_addr = AW'(32'h300);
            in_cnt_array = pack4(CW'(1000), CW'(1000), CW'(1000), CW'(1000));
            if (rdy) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e = mk(AW'(32'h3FFFFF), CW'(32'hFFFFFFFF));
                end
                chk("beat_addr", 64'(out_addr), 64'(e.addr));
                chk("beat_cnt", 64'(out_cnt), 64'(e.cnt));
                chk("beat_last", 64'(out_last), 64'(beats == NE - 1));
                beats++;
                held = 1'b0;
            end else begin
                held   = 1'b1;
                hold_a = out_addr;
                hold_c = out_cnt;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("dump_beats", 64'(beats), 64'(NE));
        chk("dump_end_valid", 64'(out_valid), 64'd0);
        chk("dump_end_busy", 64'(busy), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        beat_t z;
        z = mk(AW'(0), CW'(0));
        rst = 1'b1; query_rst_n = 1'b1; in_valid = 1'b0; in_addr = '0;
        in_cnt_array = '0; thresh = CW'(2); dump_req = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Sample table: each row is followed by a full dump of the CAM.
        add_vec(AW'(32'h10), 5, 3, 7, 4, 2, mk(AW'(32'h10), 3), z, z, z, z);
        add_vec(AW'(32'h20), 9, 12, 9, 15, 2, mk(AW'(32'h20), 9), mk(AW'(32'h10), 3), z, z, z);
        add_vec(AW'(32'h30), 6, 8, 7, 6, 2, mk(AW'(32'h20), 9), mk(AW'(32'h30), 6), mk(AW'(32'h10), 3), z, z);
        add_vec(AW'(32'h10), 10, 11, 12, 13, 2, mk(AW'(32'h10), 10), mk(AW'(32'h20), 9), mk(AW'(32'h30), 6), z, z);
        add_vec(AW'(32'h40), 1, 5, 5, 5, 2, mk(AW'(32'h10), 10), mk(AW'(32'h20), 9), mk(AW'(32'h30), 6), z, z);
        add_vec(AW'(32'h50), 9, 9, 9, 9, 2, mk(AW'(32'h10), 10), mk(AW'(32'h20), 9), mk(AW'(32'h50), 9),
                mk(AW'(32'h30), 6), z);
        add_vec(AW'(32'h30), 9, 10, 11, 12, 2, mk(AW'(32'h10), 10), mk(AW'(32'h20), 9), mk(AW'(32'h50), 9),
                mk(AW'(32'h30), 9), z);
        add_vec(AW'(32'h60), 4, 4, 4, 4, 4, mk(AW'(32'h10), 10), mk(AW'(32'h20), 9), mk(AW'(32'h50), 9),
                mk(AW'(32'h30), 9), mk(AW'(32'h60), 4));
        for (int v = 0; v < vtab.size(); v++) begin
            sample(vtab[v].addr, pack4(vtab[v].c0, vtab[v].c1, vtab[v].c2, vtab[v].c3), vtab[v].th);
            for (int k = 0; k < 5; k++) exp_q.push_back(vtab[v].e[k]);
            for (int k = 5; k < NE; k++) exp_q.push_back(z);
            run_dump(1'b0, 0);
        end

        // Back-to-back samples to one address: second must hit the first.
        qrst();
        @(negedge clk);
        in_valid = 1'b1; in_addr = AW'(32'h77); thresh = CW'(2);
        in_cnt_array = pack4(CW'(20), CW'(25), CW'(30), CW'(20));
        @(negedge clk);
        in_cnt_array = pack4(CW'(22), CW'(21), CW'(30), CW'(40));
        @(negedge clk);
        in_valid = 1'b0;
        exp_q.push_back(mk(AW'(32'h77), CW'(21)));
        for (int k = 1; k < NE; k++) exp_q.push_back(z);
        run_dump(1'b0, 0);

        // Fill all 16 slots (100..85), then a tie with the last is dropped
        // and a 90 lands below the existing 90, evicting the 85.
        qrst();
        for (int i = 0; i < NE; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_addr = AW'(32'h100 + i);
            in_cnt_array = pack4(CW'(100 - i), CW'(200), CW'(200), CW'(200));
        end
        @(negedge clk);
        in_addr = AW'(32'h200);
        in_cnt_array = pack4(CW'(85), CW'(85), CW'(85), CW'(85));
        @(negedge clk);
        in_addr = AW'(32'h201);
        in_cnt_array = pack4(CW'(95), CW'(90), CW'(99), CW'(91));
        @(negedge clk);
        in_valid = 1'b0;
        push_fill_expect();
        run_dump(1'b1, 3);
        chk("drop_cnt_3", 64'(drop_cnt), 64'd3);
        push_fill_expect();
        run_dump(1'b0, 0);
        chk("drop_cnt_hold", 64'(drop_cnt), 64'd3);

        // Clear in the middle of a dump.
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        query_rst_n = 1'b0;
        @(negedge clk);
        query_rst_n = 1'b1;
        out_ready = 1'b0;
        chk("qrst_out_valid", 64'(out_valid), 64'd0);
        chk("qrst_busy", 64'(busy), 64'd0);
        chk("qrst_out_addr", 64'(out_addr), 64'd0);
        chk("qrst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        chk("qrst_no_beat", 64'(out_valid), 64'd0);
        for (int k = 0; k < NE; k++) exp_q.push_back(z);
        run_dump(1'b0, 0);
        chk("final_drop_cnt", 64'(drop_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
